// File: rtl/msk_rnd_pkg.sv
// rtl/msk_rnd_pkg.sv - shared constants, state encoding and LFSR step for the randomness feeder
package msk_rnd_pkg;

    localparam int                LFSR_W    = 32;
    // x^32 + x^22 + x^2 + x + 1 in right-shift Galois form
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 32'h8020_0003;
    // An all-zero lane would lock up, so a zero seed word is replaced by this value
    localparam logic [LFSR_W-1:0] ZERO_SEED = 32'h0000_0001;

    typedef enum logic [1:0] {
        SEED   = 2'd0,
        WARMUP = 2'd1,
        RUN    = 2'd2
    } rnd_state_e;

    // One Galois step: shift right, fold the taps back in when a one falls out
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        logic [LFSR_W-1:0] n;
        n = s >> 1;
        if (s[0]) begin
            n = n ^ LFSR_TAPS;
        end
        return n;
    endfunction

endpackage

// File: rtl/msk_lfsr32_lane.sv
// rtl/msk_lfsr32_lane.sv - one seeded 32-bit Galois LFSR lane with load/step/hold
module msk_lfsr32_lane
    import msk_rnd_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [LFSR_W-1:0] i_load_data,
    input  logic              i_step,
    output logic              o_bit0,
    output logic              o_next_bit0
);

    logic [LFSR_W-1:0] r_state;
    logic [LFSR_W-1:0] w_next;

    assign w_next      = lfsr_step(r_state);
    assign o_bit0      = r_state[0];
    // Lets the top register the post-step bit on the same edge the lane steps
    assign o_next_bit0 = w_next[0];

    // Lane state: load wins over step, otherwise hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= '0;
        end else if (i_load) begin
            r_state <= i_load_data;
        end else if (i_step) begin
            r_state <= w_next;
        end
    end

endmodule

// File: rtl/msk_rnd_feeder.sv
// rtl/msk_rnd_feeder.sv - seeded LFSR bank feeding gadget rnd; MSK_RND_HEALTH_EN adds a stuck-output check
module msk_rnd_feeder
    import msk_rnd_pkg::*;
#(
    parameter  int d         = 2,
    parameter  int WARM      = 64,
    parameter  int STUCK_LIM = 16,
    localparam int W         = d * (d - 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [LFSR_W-1:0] seed_data,
    input  logic              seed_valid,
    output logic              seed_ready,
    input  logic              reseed,
    input  logic              rnd_en,
    output logic [W-1:0]      rnd,
    output logic              rnd_valid,
    output logic              health_err
);

    localparam int              LCW       = (W > 1) ? $clog2(W) : 1;
    localparam int              WCW       = (WARM > 0) ? $clog2(WARM + 1) : 1;
    localparam logic [LCW-1:0]  LANE_LAST = LCW'(W - 1);
    localparam logic [WCW-1:0]  WARM_LAST = WCW'(WARM);

    if (STUCK_LIM < 1) begin : g_bad_lim
        $error("STUCK_LIM must be at least 1");
    end

    rnd_state_e        r_state;
    logic [LCW-1:0]    r_lane_cnt;
    logic [WCW-1:0]    r_warm_cnt;
    logic [W-1:0]      r_rnd;
    logic              r_rnd_valid;
    logic              w_accept;
    logic              w_step;
    logic [LFSR_W-1:0] w_seed_word;
    logic [W-1:0]      w_load;
    logic [W-1:0]      w_lane_bits;
    logic [W-1:0]      w_step_bits;

    assign seed_ready  = (r_state == SEED) && !reseed;
    assign w_accept    = seed_valid && seed_ready;
    assign w_seed_word = (seed_data == '0) ? ZERO_SEED : seed_data;
    // Warm-up steps freely until the count is reached; RUN steps only for the consumer
    assign w_step      = !reseed &&
                         (((r_state == WARMUP) && (r_warm_cnt != WARM_LAST)) ||
                          ((r_state == RUN) && rnd_en));

    for (genvar k = 0; k < W; k++) begin : g_lane
        assign w_load[k] = w_accept && (r_lane_cnt == LCW'(k));
        msk_lfsr32_lane u_lane (
            .clk         (clk),
            .rst         (rst),
            .i_load      (w_load[k]),
            .i_load_data (w_seed_word),
            .i_step      (w_step),
            .o_bit0      (w_lane_bits[k]),
            .o_next_bit0 (w_step_bits[k])
        );
    end

`ifdef MSK_RND_HEALTH_EN
    localparam int             SCW        = (STUCK_LIM > 1) ? $clog2(STUCK_LIM) : 1;
    localparam logic [SCW-1:0] STUCK_LAST = SCW'(STUCK_LIM - 1);
    logic [SCW-1:0] r_stuck_cnt;
    logic           r_health_err;
    assign health_err = r_health_err;
`else
    assign health_err = 1'b0;
`endif

    assign rnd       = r_rnd;
    assign rnd_valid = r_rnd_valid;

    // Sequencer: seeding, warm-up count, output register and optional stuck detector
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= SEED;
            r_lane_cnt  <= '0;
            r_warm_cnt  <= '0;
            r_rnd       <= '0;
            r_rnd_valid <= 1'b0;
`ifdef MSK_RND_HEALTH_EN
            r_stuck_cnt  <= '0;
            r_health_err <= 1'b0;
`endif
        end else if (reseed) begin
            r_state     <= SEED;
            r_lane_cnt  <= '0;
            r_warm_cnt  <= '0;
            r_rnd       <= '0;
            r_rnd_valid <= 1'b0;
`ifdef MSK_RND_HEALTH_EN
            r_stuck_cnt  <= '0;
            r_health_err <= 1'b0;
`endif
        end else begin
            case (r_state)
                SEED: begin
                    if (w_accept) begin
                        if (r_lane_cnt == LANE_LAST) begin
                            r_state    <= WARMUP;
                            r_lane_cnt <= '0;
                            r_warm_cnt <= '0;
                        end else begin
                            r_lane_cnt <= r_lane_cnt + 1'b1;
                        end
                    end
                end
                WARMUP: begin
                    // With WARM=0 this is the single edge that publishes the seeds' bit 0
                    if (r_warm_cnt == WARM_LAST) begin
                        r_state     <= RUN;
                        r_rnd       <= w_lane_bits;
                        r_rnd_valid <= 1'b1;
`ifdef MSK_RND_HEALTH_EN
                        r_stuck_cnt <= '0;
`endif
                    end else begin
                        r_warm_cnt <= r_warm_cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (rnd_en) begin
`ifdef MSK_RND_HEALTH_EN
                        if (r_health_err) begin
                            r_rnd <= '0;
                        end else if (w_step_bits == r_rnd) begin
                            if (r_stuck_cnt == STUCK_LAST) begin
                                r_health_err <= 1'b1;
                                r_rnd_valid  <= 1'b0;
                                r_rnd        <= '0;
                            end else begin
                                r_stuck_cnt <= r_stuck_cnt + 1'b1;
                                r_rnd       <= w_step_bits;
                            end
                        end else begin
                            r_stuck_cnt <= '0;
                            r_rnd       <= w_step_bits;
                        end
`else
                        r_rnd <= w_step_bits;
`endif
                    end
                end
                default: begin
                    r_state <= SEED;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_msk_rnd_feeder.sv
// tb/tb_msk_rnd_feeder.sv - directed self-checking bench for msk_rnd_feeder
module tb_msk_rnd_feeder;

`ifdef MSK_RND_HEALTH_EN
    localparam bit HEALTH = 1'b1;
`else
    localparam bit HEALTH = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [31:0] a_seed_data  = '0;
    logic        a_seed_valid = 1'b0;
    logic        a_seed_ready;
    logic        a_reseed     = 1'b0;
    logic        a_rnd_en     = 1'b0;
    logic [1:0]  a_rnd;
    logic        a_rnd_valid;
    logic        a_health_err;

    logic [31:0] b_seed_data  = '0;
    logic        b_seed_valid = 1'b0;
    logic        b_seed_ready;
    logic        b_reseed     = 1'b0;
    logic        b_rnd_en     = 1'b0;
    logic [1:0]  b_rnd;
    logic        b_rnd_valid;
    logic        b_health_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    msk_rnd_feeder #(.d(2), .WARM(0), .STUCK_LIM(4)) u_dut_a (
        .clk        (clk),
        .rst        (rst),
        .seed_data  (a_seed_data),
        .seed_valid (a_seed_valid),
        .seed_ready (a_seed_ready),
        .reseed     (a_reseed),
        .rnd_en     (a_rnd_en),
        .rnd        (a_rnd),
        .rnd_valid  (a_rnd_valid),
        .health_err (a_health_err)
    );

    msk_rnd_feeder #(.d(2), .WARM(64)) u_dut_b (
        .clk        (clk),
        .rst        (rst),
        .seed_data  (b_seed_data),
        .seed_valid (b_seed_valid),
        .seed_ready (b_seed_ready),
        .reseed     (b_reseed),
        .rnd_en     (b_rnd_en),
        .rnd        (b_rnd),
        .rnd_valid  (b_rnd_valid),
        .health_err (b_health_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] hold_seq [0:1];
        logic [1:0] zero_seq [0:2];
        bit         early;
        hold_seq = '{2'b01, 2'b11};
        zero_seq = '{2'b11, 2'b11, 2'b00};

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_rnd",    a_rnd, 0);
        chk("rst_valid",  a_rnd_valid, 0);
        chk("rst_health", a_health_err, 0);
        chk("rst_ready",  a_seed_ready, 1);
        chk("rst_ready_b", b_seed_ready, 1);

        // seeds 1,2 with WARM=0
        a_seed_valid = 1'b1;
        a_seed_data  = 32'h1;
        tick();
        a_seed_data  = 32'h2;
        tick();
        a_seed_valid = 1'b0;
        a_rnd_en     = 1'b1;
        #1;
        chk("ready_after_seed", a_seed_ready, 0);
        chk("valid_at_accept",  a_rnd_valid, 0);
        tick();
        chk("valid_rise", a_rnd_valid, 1);
        chk("seq12_0", a_rnd, 2'b01);
        tick();
        chk("seq12_1", a_rnd, 2'b11);
        tick();
        chk("seq12_2", a_rnd, 2'b10);

        // rnd_en low holds, then sequence resumes
        a_rnd_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_rnd", a_rnd, 2'b10);
        end
        a_rnd_en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("resume_rnd", a_rnd, hold_seq[i]);
        end

        // reseed collides with a seed word
        a_reseed     = 1'b1;
        a_seed_valid = 1'b1;
        a_seed_data  = 32'h5;
        #1;
        chk("ready_during_reseed", a_seed_ready, 0);
        tick();
        a_reseed     = 1'b0;
        a_seed_valid = 1'b0;
        #1;
        chk("reseed_rnd",   a_rnd, 0);
        chk("reseed_valid", a_rnd_valid, 0);
        chk("reseed_ready", a_seed_ready, 1);

        // zero seeds behave as 1; the colliding word must not have been counted
        a_seed_valid = 1'b1;
        a_seed_data  = 32'h0;
        tick();
        chk("one_word_ready", a_seed_ready, 1);
        tick();
        a_seed_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("zero_valid", a_rnd_valid, 1);
            chk("zero_seq", a_rnd, zero_seq[i]);
        end

        // reset mid-SEED after one word
        a_rnd_en = 1'b0;
        a_reseed = 1'b1;
        tick();
        a_reseed     = 1'b0;
        a_seed_valid = 1'b1;
        a_seed_data  = 32'h8000_0000;
        tick();
        a_seed_valid = 1'b0;
        rst = 1'b1;
        #2;
        chk("midrst_ready", a_seed_ready, 1);
        chk("midrst_valid", a_rnd_valid, 0);
        chk("midrst_rnd",   a_rnd, 0);
        rst = 1'b0;
        a_seed_valid = 1'b1;
        tick();
        chk("restart_ready", a_seed_ready, 1);
        tick();
        a_seed_valid = 1'b0;
        tick();
        chk("stuck_valid0", a_rnd_valid, 1);
        chk("stuck_rnd0",   a_rnd, 2'b00);

        // identical all-zero outputs repeat; the health check trips at the 4th repeat
        a_rnd_en = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("stuck_rnd",    a_rnd, 2'b00);
            chk("stuck_health", a_health_err, (HEALTH && i == 4) ? 1 : 0);
            chk("stuck_valid",  a_rnd_valid,  (HEALTH && i == 4) ? 0 : 1);
        end
        a_rnd_en = 1'b0;
        a_reseed = 1'b1;
        tick();
        a_reseed = 1'b0;
        #1;
        chk("clr_health", a_health_err, 0);
        chk("clr_valid",  a_rnd_valid, 0);

        // WARM=64 with gapped seed_valid
        b_seed_valid = 1'b1;
        b_seed_data  = 32'h1;
        tick();
        b_seed_valid = 1'b0;
        tick();
        chk("gap_ready", b_seed_ready, 1);
        b_seed_valid = 1'b1;
        b_seed_data  = 32'h2;
        tick();
        b_seed_valid = 1'b0;
        #1;
        chk("warm_ready_drop", b_seed_ready, 0);
        early = 1'b0;
        for (int i = 1; i <= 64; i++) begin
            tick();
            if (b_rnd_valid) early = 1'b1;
        end
        chk("warm_no_early", early, 0);
        tick();
        chk("warm_valid_65", b_rnd_valid, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
